gpt_ic_conditioner: RTL and testbench
=====================================

Name: gpt_ic_conditioner

Overview:
Per-channel input-capture front end for the general-purpose timer, directly upstream of each timer channel.
- Synchronises the raw channel pin and applies the ICxF digital filter, clocked at fCK_INT or at fDTS scaled by CKD.
- Produces the filtered level, the polarity-adjusted level (TIxFPx), the any-edge pulse (TI1F_ED), and the prescaled capture strobe (ICxPS).
- One instance per channel inside the timer top; outputs feed the channel's capture/compare logic and the trigger controller.

Parameters:
SYNC_STAGES, 2, number of input synchroniser flops (minimum 2)
DIV_W, 7, width of the sample-period counter (max period 4*32=128 cycles)

Ports:
clk_i  input  1  timer kernel clock (fCK_INT)
rst_i  input  1  reset, synchronous, active-high
ti_i  input  1  raw asynchronous channel pin
icf_i  input  4  ICxF filter selection
ckd_i  input  2  CKD, fDTS = fCK_INT / {1,2,4}; 2'b11 treated as 2'b00
ccp_i  input  1  CCxP polarity bit
ccnp_i  input  1  CCxNP polarity bit
icpsc_i  input  2  ICxPSC: capture every 1/2/4/8 events
cap_en_i  input  1  CCxE capture enable
tif_o  output  1  filtered level (TIxF)
tifp_o  output  1  polarity-adjusted level (TIxFPx); inverted when {ccnp,ccp}=01
ti_ed_o  output  1  one-cycle pulse on any edge of tif_o (TIxF_ED)
ic_o  output  1  one-cycle prescaled capture strobe (ICxPS)

Behaviour:
Reset
- All flops clear on rst_i at clk_i edge: synchroniser, tif, tif_d, divider, filter count, prescaler count.
- All outputs are 0 in the cycle after reset.
- Reset mid-filter discards the partial count; no edge or capture pulse is emitted.

Sample tick
- Period P = dts_div * fs_div.
- dts_div = 1/2/4 from ckd_i.
- fs_div from icf_i: 0000-0011 -> 1 and P is forced to 1, ignoring CKD; 0100-0101 -> 2; 0110-0111 -> 4; 1000-1001 -> 8; 1010-1100 -> 16; 1101-1111 -> 32.
- Free-running counter 0..P-1; tick when count == P-1, then wrap to 0.

Required sample count N by icf_i
- 0000: 1 (no filter)
- 0001: 2; 0010: 4; 0011: 8
- 0100: 6; 0101: 8; 0110: 6; 0111: 8; 1000: 6; 1001: 8
- 1010: 5; 1011: 6; 1100: 8
- 1101: 5; 1110: 6; 1111: 8

Filter, evaluated on each tick with synchronised sample s
- s == tif: count clears.
- s != tif and count == N-1: tif toggles and count clears.
- Otherwise count increments.
- Any change of icf_i or ckd_i clears divider and count in the following cycle; tif is held.

Latency
- ICF=0000: ti_i to tif_o is SYNC_STAGES+1 cycles.
- ICF with P=1: SYNC_STAGES+N cycles.
- P>1: between SYNC_STAGES+(N-1)*P+1 and SYNC_STAGES+N*P cycles.

Edge and polarity
- tif_d is tif_o delayed one cycle.
- ti_ed_o = tif_o ^ tif_d, high in the first cycle of the new level.
- {ccnp,ccp} selects the capture event: 00 rising of tif; 01 falling; 11 both; 10 reserved, treated as rising.

Capture prescaler
- 3-bit counter, divisor D = 1/2/4/8.
- On each selected event with cap_en_i=1:
  - counter == D-1: ic_o=1 for one cycle and counter wraps to 0.
  - otherwise counter increments.
- Counter cleared while cap_en_i=0 or in the cycle after any icpsc_i change.
- ic_o is registered: high the cycle after tif_o changes, the same cycle ti_ed_o falls.
- An event coinciding with a clear is dropped.

Optional Feature:
GPT_IC_GLITCH_CNT_EN
- Defined: adds output glitch_cnt_o [7:0], a saturating count of rejected glitches. A glitch is a tick where count != 0 and s == tif. Cleared by rst_i; saturates at 255.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package gpt_ic_pkg:
  - icf decode function returning {fs_div_log2, N}.
  - Enum ic_pol_e (RISE, FALL, BOTH).
  - Enum ic_psc_e (DIV1..DIV8).
  - Constant MAX_N=8.
- Sub-module gpt_ic_filter: synchroniser, sample divider and N-sample filter, producing tif_o. The parent holds edge detect, polarity and prescaler.

Test Plan:
- ICF=0000, SYNC_STAGES=2, ti_i rises at cycle 0 -> tif_o=1 at cycle 3; ti_ed_o pulses at cycle 3; ic_o pulses at cycle 4 with {ccnp,ccp}=00, cap_en=1.
- ICF=0011: 7-cycle high pulse -> tif_o stays 0, no ic_o. 8-cycle pulse -> tif_o=1 at cycle 10.
- ICF=0100 (fs_div 2, N=6), CKD=01 so P=4: 16-cycle pulse rejected; 32-cycle pulse accepted within cycles 23..26.
- {ccnp,ccp}=11, ICPSC=10 (div 4), eight clean edges -> exactly 2 ic_o pulses, on the 4th and 8th edges. Deassert cap_en mid-sequence -> counter restarts from 0.
- Reset asserted while the filter count is at 5 of N=8 -> all outputs 0, subsequent 3-cycle high gives no tif_o change.
- With GPT_IC_GLITCH_CNT_EN, ICF=0011, 300 2-cycle pulses -> glitch_cnt_o saturates at 255 and tif_o stays 0.

Source files
------------

// File: rtl/gpt_ic_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gpt_ic_pkg
// Brief    : Shared types and decode helpers for the timer input-capture path.
// Revision : 1.0 - initial release
// ============================================================================
package gpt_ic_pkg;

    localparam int MAX_N   = 8;
    localparam int c_CNT_W = $clog2(MAX_N);

    typedef enum logic [1:0] {
        RISE = 2'd0,
        FALL = 2'd1,
        BOTH = 2'd2
    } ic_pol_e;

    typedef enum logic [1:0] {
        DIV1 = 2'd0,
        DIV2 = 2'd1,
        DIV4 = 2'd2,
        DIV8 = 2'd3
    } ic_psc_e;

    typedef struct packed {
        logic [2:0] fs_log2;
        logic [3:0] n;
    } icf_cfg_t;

    // fs_log2 of 0 for ICF 0000-0011 means "sample every fCK_INT cycle".
    function automatic icf_cfg_t icf_decode(input logic [3:0] icf);
        icf_cfg_t r;
        case (icf)
            4'b0000: r = '{fs_log2: 3'd0, n: 4'd1};
            4'b0001: r = '{fs_log2: 3'd0, n: 4'd2};
            4'b0010: r = '{fs_log2: 3'd0, n: 4'd4};
            4'b0011: r = '{fs_log2: 3'd0, n: 4'd8};
            4'b0100: r = '{fs_log2: 3'd1, n: 4'd6};
            4'b0101: r = '{fs_log2: 3'd1, n: 4'd8};
            4'b0110: r = '{fs_log2: 3'd2, n: 4'd6};
            4'b0111: r = '{fs_log2: 3'd2, n: 4'd8};
            4'b1000: r = '{fs_log2: 3'd3, n: 4'd6};
            4'b1001: r = '{fs_log2: 3'd3, n: 4'd8};
            4'b1010: r = '{fs_log2: 3'd4, n: 4'd5};
            4'b1011: r = '{fs_log2: 3'd4, n: 4'd6};
            4'b1100: r = '{fs_log2: 3'd4, n: 4'd8};
            4'b1101: r = '{fs_log2: 3'd5, n: 4'd5};
            4'b1110: r = '{fs_log2: 3'd5, n: 4'd6};
            default: r = '{fs_log2: 3'd5, n: 4'd8};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] ckd_log2(input logic [1:0] ckd);
        case (ckd)
            2'b01:   return 2'd1;
            2'b10:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic ic_pol_e pol_decode(input logic ccnp, input logic ccp);
        case ({ccnp, ccp})
            2'b01:   return FALL;
            2'b11:   return BOTH;
            default: return RISE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpt_ic_filter.sv
`default_nettype none
// ============================================================================
// Module   : gpt_ic_filter
// Brief    : Pin synchroniser, sample-period divider and N-sample digital filter.
// Options  : GPT_IC_GLITCH_CNT_EN adds glitch_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
module gpt_ic_filter
    import gpt_ic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ti_i,
    input  logic [3:0] icf_i,
    input  logic [1:0] ckd_i,
    output logic       tif_o
`ifdef GPT_IC_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt_o
`endif
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DIV_W-1:0]       r_div;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_tif;
    logic [3:0]             r_icf_d;
    logic [1:0]             r_ckd_d;

    icf_cfg_t               w_cfg;
    logic [2:0]             w_p_log2;
    logic [DIV_W-1:0]       w_p_m1;
    logic [c_CNT_W-1:0]     w_n_m1;
    logic                   w_s;
    logic                   w_tick;
    logic                   w_cfg_chg;

    assign w_cfg     = icf_decode(icf_i);
    // The CKD prescale only applies once the filter uses a divided sampling clock.
    assign w_p_log2  = (icf_i[3:2] == 2'b00) ? 3'd0
                     : w_cfg.fs_log2 + {1'b0, ckd_log2(ckd_i)};
    assign w_p_m1    = DIV_W'((32'd1 << w_p_log2) - 32'd1);
    assign w_n_m1    = c_CNT_W'(w_cfg.n - 4'd1);
    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_tick    = (r_div == w_p_m1);
    assign w_cfg_chg = (icf_i != r_icf_d) || (ckd_i != r_ckd_d);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync  <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_tif   <= 1'b0;
            r_icf_d <= '0;
            r_ckd_d <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], ti_i};
            r_icf_d <= icf_i;
            r_ckd_d <= ckd_i;
            if (w_cfg_chg) begin
                r_div <= '0;
                r_cnt <= '0;
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    if (w_s == r_tif) begin
                        r_cnt <= '0;
                    end else if (r_cnt == w_n_m1) begin
                        r_tif <= ~r_tif;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign tif_o = r_tif;

`ifdef GPT_IC_GLITCH_CNT_EN
    logic [7:0] r_glitch;

    // A glitch is a partially counted excursion that the pin abandoned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_glitch <= '0;
        end else if (!w_cfg_chg && w_tick && (r_cnt != '0) && (w_s == r_tif)
                     && (r_glitch != 8'hFF)) begin
            r_glitch <= r_glitch + 1'b1;
        end
    end

    assign glitch_cnt_o = r_glitch;
`endif

endmodule
`default_nettype wire

// File: rtl/gpt_ic_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : gpt_ic_conditioner
// Brief    : Per-channel capture front end: filter, edge detect, polarity, prescaler.
// Options  : GPT_IC_GLITCH_CNT_EN adds glitch_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
module gpt_ic_conditioner
    import gpt_ic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ti_i,
    input  logic [3:0] icf_i,
    input  logic [1:0] ckd_i,
    input  logic       ccp_i,
    input  logic       ccnp_i,
    input  logic [1:0] icpsc_i,
    input  logic       cap_en_i,
    output logic       tif_o,
    output logic       tifp_o,
    output logic       ti_ed_o,
    output logic       ic_o
`ifdef GPT_IC_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt_o
`endif
);

    logic       w_tif;
    logic       w_ed;
    logic       w_sel;
    logic       w_clr;
    logic [2:0] w_d_m1;
    ic_pol_e    w_pol;
    ic_psc_e    w_psc;

    logic       r_tif_d;
    logic [1:0] r_psc_d;
    logic [2:0] r_pcnt;
    logic       r_ic;

    gpt_ic_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DIV_W       (DIV_W)
    ) u_filter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ti_i         (ti_i),
        .icf_i        (icf_i),
        .ckd_i        (ckd_i),
        .tif_o        (w_tif)
`ifdef GPT_IC_GLITCH_CNT_EN
        ,
        .glitch_cnt_o (glitch_cnt_o)
`endif
    );

    assign w_ed  = w_tif ^ r_tif_d;
    assign w_pol = pol_decode(ccnp_i, ccp_i);
    assign w_psc = ic_psc_e'(icpsc_i);
    assign w_clr = !cap_en_i || (icpsc_i != r_psc_d);

    always_comb begin
        w_sel = 1'b0;
        case (w_pol)
            RISE:    w_sel = w_ed & w_tif;
            FALL:    w_sel = w_ed & ~w_tif;
            BOTH:    w_sel = w_ed;
            default: w_sel = 1'b0;
        endcase
    end

    always_comb begin
        w_d_m1 = 3'd0;
        case (w_psc)
            DIV1:    w_d_m1 = 3'd0;
            DIV2:    w_d_m1 = 3'd1;
            DIV4:    w_d_m1 = 3'd3;
            DIV8:    w_d_m1 = 3'd7;
            default: w_d_m1 = 3'd0;
        endcase
    end

    // Clears win over events so a capture never straddles a prescaler reconfiguration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tif_d <= 1'b0;
            r_psc_d <= '0;
            r_pcnt  <= '0;
            r_ic    <= 1'b0;
        end else begin
            r_tif_d <= w_tif;
            r_psc_d <= icpsc_i;
            r_ic    <= 1'b0;
            if (w_clr) begin
                r_pcnt <= '0;
            end else if (w_sel) begin
                if (r_pcnt == w_d_m1) begin
                    r_pcnt <= '0;
                    r_ic   <= 1'b1;
                end else begin
                    r_pcnt <= r_pcnt + 1'b1;
                end
            end
        end
    end

    assign tif_o   = w_tif;
    assign tifp_o  = w_tif ^ (w_pol == FALL);
    assign ti_ed_o = w_ed;
    assign ic_o    = r_ic;

endmodule
`default_nettype wire

// File: tb/tb_gpt_ic_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpt_ic_conditioner
// Brief    : Randomised scoreboard bench for gpt_ic_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpt_ic_conditioner;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       ti_i = 1'b0;
    logic [3:0] icf_i = '0;
    logic [1:0] ckd_i = '0;
    logic       ccp_i = 1'b0;
    logic       ccnp_i = 1'b0;
    logic [1:0] icpsc_i = '0;
    logic       cap_en_i = 1'b1;
    logic       tif_o, tifp_o, ti_ed_o, ic_o;
`ifdef GPT_IC_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_o;
`endif

    always #5 clk = ~clk;

    gpt_ic_conditioner #(.SYNC_STAGES(SYNC), .DIV_W(7)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .ti_i     (ti_i),
        .icf_i    (icf_i),
        .ckd_i    (ckd_i),
        .ccp_i    (ccp_i),
        .ccnp_i   (ccnp_i),
        .icpsc_i  (icpsc_i),
        .cap_en_i (cap_en_i),
        .tif_o    (tif_o),
        .tifp_o   (tifp_o),
        .ti_ed_o  (ti_ed_o),
        .ic_o     (ic_o)
`ifdef GPT_IC_GLITCH_CNT_EN
        ,
        .glitch_cnt_o (glitch_cnt_o)
`endif
    );

    typedef struct {
        bit level;
        bit inv;
        int t0;
        int lo;
        int hi;
    } edge_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } req_t;

    edge_t edge_q[$];
    bit    cap_q[$];
    req_t  req_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int ic_total = 0;

    // Reference tables: required samples N and sampling divider per ICF code.
    int n_tab[16]  = '{1, 2, 4, 8, 6, 8, 6, 8, 6, 8, 5, 6, 8, 5, 6, 8};
    int fs_tab[16] = '{1, 1, 1, 1, 2, 2, 4, 4, 8, 8, 16, 16, 16, 32, 32, 32};

    int m_cnt = 0;
    int m_psc_prev = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void chk_rng(string nm, int act, int lo, int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
        end
    endfunction

    // Monitor: sole owner of the comparison counters.
    initial begin : monitor
        edge_t e;
        req_t  r;
        bit    lv;
        bit    prev_ed;
        bit    prev_tif;
        prev_ed  = 1'b0;
        prev_tif = 1'b0;
        forever begin
            @(negedge clk);
            while (req_q.size() > 0) begin
                r = req_q.pop_front();
                chk(r.name, r.act, r.exp);
            end
            if (ti_ed_o) begin
                if (edge_q.size() == 0) begin
                    chk("unexpected_edge", 1, 0);
                end else begin
                    e = edge_q.pop_front();
                    chk("edge_level", int'(tif_o), int'(e.level));
                    chk("edge_tifp", int'(tifp_o), int'(e.level ^ e.inv));
                    chk_rng("edge_latency", cyc - e.t0, e.lo, e.hi);
                end
            end
            if (ic_o) begin
                ic_total++;
                if (cap_q.size() == 0) begin
                    chk("unexpected_capture", 1, 0);
                end else begin
                    lv = cap_q.pop_front();
                    chk("capture_level", int'(prev_tif), int'(lv));
                    chk("capture_after_edge", int'(prev_ed), 1);
                end
            end
            prev_ed  = ti_ed_o;
            prev_tif = tif_o;
        end
    end

    task automatic req(input string nm, input int act, input int exp);
        req_t r;
        r.name = nm;
        r.act  = act;
        r.exp  = exp;
        req_q.push_back(r);
    endtask

    task automatic model_event(input bit rise, input bit ccnp, input bit ccp,
                               input int psc, input bit cap_en);
        bit sel;
        sel = rise ? !(!ccnp && ccp) : ccp;
        if (sel && cap_en) begin
            if (m_cnt == (1 << psc) - 1) begin
                cap_q.push_back(rise);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // One transaction: configure, drive a single high pulse of len cycles, then idle.
    task automatic run_txn(input int icf, input int ckd, input bit ccnp, input bit ccp,
                           input int psc, input bit cap_en, input int len);
        int    n, p, lo, hi;
        bit    acc, inv;
        edge_t e;
        @(negedge clk);
        icf_i    = 4'(icf);
        ckd_i    = 2'(ckd);
        ccnp_i   = ccnp;
        ccp_i    = ccp;
        icpsc_i  = 2'(psc);
        cap_en_i = cap_en;
        if (psc != m_psc_prev || !cap_en) m_cnt = 0;
        m_psc_prev = psc;
        repeat (4) @(negedge clk);
        n   = n_tab[icf];
        p   = (icf < 4) ? 1 : fs_tab[icf] * ((ckd == 1) ? 2 : (ckd == 2) ? 4 : 1);
        acc = (len >= n * p);
        inv = !ccnp && ccp;
        if (p == 1) begin
            lo = SYNC + n;
            hi = SYNC + n;
        end else begin
            lo = SYNC + (n - 1) * p + 1;
            hi = SYNC + n * p;
        end
        ti_i = 1'b1;
        if (acc) begin
            e = '{level: 1'b1, inv: inv, t0: cyc, lo: lo, hi: hi};
            edge_q.push_back(e);
            model_event(1'b1, ccnp, ccp, psc, cap_en);
        end
        repeat (len) @(negedge clk);
        ti_i = 1'b0;
        if (acc) begin
            e = '{level: 1'b0, inv: inv, t0: cyc, lo: lo, hi: hi};
            edge_q.push_back(e);
            model_event(1'b0, ccnp, ccp, psc, cap_en);
        end
        repeat (n * p + SYNC + p + 6) @(negedge clk);
        req("edges_drained", edge_q.size(), 0);
        req("captures_drained", cap_q.size(), 0);
    endtask

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int icf, ckd, n, p, len;
        repeat (3) @(negedge clk);
        req("reset_tif", int'(tif_o), 0);
        req("reset_tifp", int'(tifp_o), 0);
        req("reset_ed", int'(ti_ed_o), 0);
        req("reset_ic", int'(ic_o), 0);
        rst_i = 1'b0;
        m_cnt = 0;
        m_psc_prev = 0;

        // Unfiltered path: exact latency of SYNC+1, capture the following cycle.
        run_txn(0, 0, 1'b0, 1'b0, 0, 1'b1, 20);
        // 8-sample filter at fCK_INT: 7 rejected, 8 accepted at SYNC+8.
        run_txn(3, 0, 1'b0, 1'b0, 0, 1'b1, 7);
        run_txn(3, 0, 1'b0, 1'b1, 0, 1'b1, 8);
        // fs_div 2 with CKD /2: P=4, N=6.
        run_txn(4, 1, 1'b0, 1'b0, 0, 1'b1, 16);
        run_txn(4, 1, 1'b1, 1'b1, 0, 1'b1, 32);

        // Both-edge capture, divide by 4: eight edges give two captures.
        base = ic_total;
        for (int i = 0; i < 4; i++) run_txn(0, 0, 1'b1, 1'b1, 2, 1'b1, 5);
        @(negedge clk);
        req("psc_div4_count", ic_total - base, 2);
        base = ic_total;
        run_txn(0, 0, 1'b1, 1'b1, 2, 1'b1, 5);
        run_txn(0, 0, 1'b1, 1'b1, 2, 1'b0, 5);
        for (int i = 0; i < 2; i++) run_txn(0, 0, 1'b1, 1'b1, 2, 1'b1, 5);
        @(negedge clk);
        req("psc_restart_count", ic_total - base, 1);

        // Reset while the 8-sample filter has counted 5.
        @(negedge clk);
        icf_i = 4'd3; ckd_i = 2'd0; ccnp_i = 1'b0; ccp_i = 1'b0; cap_en_i = 1'b1;
        repeat (4) @(negedge clk);
        ti_i = 1'b1;
        repeat (7) @(negedge clk);
        rst_i = 1'b1;
        ti_i  = 1'b0;
        @(negedge clk);
        req("midreset_tif", int'(tif_o), 0);
        req("midreset_ed", int'(ti_ed_o), 0);
        req("midreset_ic", int'(ic_o), 0);
        rst_i = 1'b0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        ti_i = 1'b1;
        repeat (3) @(negedge clk);
        ti_i = 1'b0;
        repeat (20) @(negedge clk);
        req("postreset_tif", int'(tif_o), 0);
        req("postreset_edges", edge_q.size(), 0);

        // Randomised transactions, pulse lengths kept outside the ambiguous window.
        for (int t = 0; t < 40; t++) begin
            icf = $urandom_range(0, 15);
            ckd = (icf >= 10) ? $urandom_range(0, 1) : $urandom_range(0, 3);
            n   = n_tab[icf];
            p   = (icf < 4) ? 1 : fs_tab[icf] * ((ckd == 1) ? 2 : (ckd == 2) ? 4 : 1);
            if (n > 1 && ($urandom % 2) == 0)
                len = $urandom_range(1, (n - 1) * p);
            else
                len = $urandom_range(n * p, n * p + p + 2);
            run_txn(icf, ckd, 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                    ($urandom % 4) != 0, len);
        end

`ifdef GPT_IC_GLITCH_CNT_EN
        @(negedge clk);
        icf_i = 4'd3; ckd_i = 2'd0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            ti_i = 1'b1;
            repeat (2) @(negedge clk);
            ti_i = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        req("glitch_saturated", int'(glitch_cnt_o), 255);
        req("glitch_tif", int'(tif_o), 0);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
